mem_arbiter: RTL and testbench

Two-port arbiter that shares the single-port, word-addressed `memory` block between the instruction-fetch stage and the load/store stage of the RISC-V core. It accepts requests from both ports through a request/grant handshake and grants at most one memory access per cycle, with round-robin priority on conflicts. It drives the memory strobes and routes the memory's registered read data back to the port that owns the in-flight access, one cycle later. It also screens out out-of-range addresses and illegal `funct3` codes before they reach memory.

---
 rtl/mem_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port word memory between instruction fetch and load/store.
// Screens illegal requests and returns the memory's registered read data one cycle after the grant.
module mem_arbiter #(
   parameter int MEMSIZE = 64
) (
   input  logic        clk,
   input  logic        reset,
   // fetch port
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_gnt,
   output logic        if_rvalid,
   output logic [31:0] if_rdata,
   output logic        if_err,
   // load/store port
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [2:0]  d_funct3,
   output logic        d_gnt,
   output logic        d_rvalid,
   output logic [31:0] d_rdata,
   output logic        d_err,
   // memory side
   output logic [31:0] mem_addr,
   output logic [31:0] mem_value,
   output logic [2:0]  mem_funct3,
   output logic        mem_read,
   output logic        mem_write,
   input  logic [31:0] mem_data
);

   typedef enum logic [2:0] {
      NONE        = 3'd0,
      RESP_IF     = 3'd1,
      RESP_D      = 3'd2,
      RESP_ERR_IF = 3'd3,
      RESP_ERR_D  = 3'd4
   } resp_state_e;

   localparam logic [2:0] FUNCT3_WORD = 3'd2;
   localparam logic       GNT_IF      = 1'b0;
   localparam logic       GNT_D       = 1'b1;

   resp_state_e resp_state_q, resp_state_d;
   logic        last_gnt_q, last_gnt_d;
   logic        was_store_q, was_store_d;

   logic        gnt_if, gnt_d;
   logic        if_legal, d_legal, d_addr_ok, d_funct3_ok;

   // Grant selection; everything is held off while reset is high.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
      gnt_if = 1'b0;
      gnt_d  = 1'b0;
      if (!reset) begin
         if (if_req && d_req) begin
            gnt_if = (last_gnt_q == GNT_D);
            gnt_d  = (last_gnt_q == GNT_IF);
         end else begin
            gnt_if = if_req;
            gnt_d  = d_req;
         end
      end
   end

   assign if_gnt = gnt_if;
   assign d_gnt  = gnt_d;

   always_comb begin
      if_legal    = (if_addr < 32'(MEMSIZE));
      d_addr_ok   = (d_addr < 32'(MEMSIZE));
      d_funct3_ok = 1'b1;
      if (d_we) begin
         d_funct3_ok = (d_funct3 <= 3'd2);
      end else begin
         d_funct3_ok = !((d_funct3 == 3'd3) || (d_funct3 == 3'd6) || (d_funct3 == 3'd7));
      end
      d_legal = d_addr_ok && d_funct3_ok;
   end

   // Memory strobes go out in the grant cycle; illegal grants leave memory untouched.
   always_comb begin
      mem_addr   = '0;
      mem_value  = '0;
      mem_funct3 = '0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      if (gnt_if && if_legal) begin
         mem_read   = 1'b1;
         mem_funct3 = FUNCT3_WORD;
         mem_addr   = if_addr;
      end else if (gnt_d && d_legal) begin
         mem_addr   = d_addr;
         mem_funct3 = d_funct3;
         if (d_we) begin
            mem_write = 1'b1;
            mem_value = d_wdata;
         end else begin
            mem_read = 1'b1;
         end
      end
   end

   // The grant made this cycle fully determines next cycle's response.
   always_comb begin
      resp_state_d = NONE;
      last_gnt_d   = last_gnt_q;
      was_store_d  = 1'b0;
      if (gnt_if) begin
         last_gnt_d   = GNT_IF;
         resp_state_d = if_legal ? RESP_IF : RESP_ERR_IF;
      end else if (gnt_d) begin
         last_gnt_d   = GNT_D;
         was_store_d  = d_we;
         resp_state_d = d_legal ? RESP_D : RESP_ERR_D;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         resp_state_q <= NONE;
         last_gnt_q   <= GNT_IF;
         was_store_q  <= 1'b0;
      end else begin
         resp_state_q <= resp_state_d;
         last_gnt_q   <= last_gnt_d;
         was_store_q  <= was_store_d;
      end
   end

   always_comb begin
      if_rvalid = 1'b0;
      if_err    = 1'b0;
      if_rdata  = '0;
      d_rvalid  = 1'b0;
      d_err     = 1'b0;
      d_rdata   = '0;
      unique case (resp_state_q)
         RESP_IF: begin
            if_rvalid = 1'b1;
            if_rdata  = mem_data;
         end
         RESP_D: begin
            d_rvalid = 1'b1;
            d_rdata  = was_store_q ? '0 : mem_data;
         end
         RESP_ERR_IF: begin
            if_rvalid = 1'b1;
            if_err    = 1'b1;
         end
         RESP_ERR_D: begin
            d_rvalid = 1'b1;
            d_err    = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a word memory model plus a scoreboard of expected
// responses pushed at grant time and popped one cycle later.
module tb_mem_arbiter;

   localparam int MEMSIZE = 64;

   logic        clk = 1'b0;
   logic        reset;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_gnt, if_rvalid, if_err;
   logic [31:0] if_rdata;
   logic        d_req, d_we;
   logic [31:0] d_addr, d_wdata;
   logic [2:0]  d_funct3;
   logic        d_gnt, d_rvalid, d_err;
   logic [31:0] d_rdata;
   logic [31:0] mem_addr, mem_value;
   logic [2:0]  mem_funct3;
   logic        mem_read, mem_write;
   logic [31:0] mem_data;

   mem_arbiter #(.MEMSIZE(MEMSIZE)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_funct3(d_funct3),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
      .mem_addr(mem_addr), .mem_value(mem_value), .mem_funct3(mem_funct3),
      .mem_read(mem_read), .mem_write(mem_write), .mem_data(mem_data)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        if_v;
      logic        if_e;
      logic [31:0] if_d;
      logic        d_v;
      logic        d_e;
      logic [31:0] d_d;
   } resp_t;

   resp_t       sbq[$];
   logic [31:0] ref_mem [MEMSIZE];
   logic [31:0] mem [MEMSIZE];
   logic        init_mem;
   logic        m_last;
   logic        m_gnt_if, m_gnt_d;
   int          n_cmp = 0;
   int          n_bad = 0;

   function automatic logic [31:0] ld_val(input logic [31:0] w, input logic [2:0] f);
      case (f)
         3'd0:    return {{24{w[7]}}, w[7:0]};
         3'd1:    return {{16{w[15]}}, w[15:0]};
         3'd2:    return w;
         3'd4:    return {24'd0, w[7:0]};
         3'd5:    return {16'd0, w[15:0]};
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic [31:0] st_val(input logic [31:0] w, input logic [31:0] v, input logic [2:0] f);
      case (f)
         3'd0:    return {w[31:8], v[7:0]};
         3'd1:    return {w[31:16], v[15:0]};
         default: return v;
      endcase
   endfunction

   // Attached single-port memory: registered read data, write on the strobe edge.
   always @(posedge clk) begin
      if (init_mem) begin
         for (int i = 0; i < MEMSIZE; i++) mem[i] <= (i == 5) ? 32'h1234_5678 : 32'd0;
      end else begin
         if (mem_write && mem_addr < MEMSIZE) mem[mem_addr[5:0]] <= st_val(mem[mem_addr[5:0]], mem_value, mem_funct3);
         if (mem_read && mem_addr < MEMSIZE) mem_data <= ld_val(mem[mem_addr[5:0]], mem_funct3);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One cycle of scoreboard checking at the falling edge: pop/compare the response,
   // predict and compare the grant and memory drive, push next cycle's expected response.
   task automatic cycle();
      resp_t       e;
      resp_t       nx;
      logic        if_ok, d_ok, exp_rd, exp_wr;
      @(negedge clk);
      e = (sbq.size() > 0) ? sbq.pop_front() : '0;
      n_cmp++;
      if ({if_rvalid, if_err, if_rdata, d_rvalid, d_err, d_rdata} !== e) begin
         n_bad++;
         $display("FAIL resp: got if v/e/d=%b/%b/%h d v/e/d=%b/%b/%h, want if %b/%b/%h d %b/%b/%h",
                  if_rvalid, if_err, if_rdata, d_rvalid, d_err, d_rdata,
                  e.if_v, e.if_e, e.if_d, e.d_v, e.d_e, e.d_d);
      end

      m_gnt_if = !reset && if_req && (!d_req || m_last);
      m_gnt_d  = !reset && d_req && (!if_req || !m_last);
      n_cmp++;
      if ({if_gnt, d_gnt} !== {m_gnt_if, m_gnt_d}) begin
         n_bad++;
         $display("FAIL gnt: got if/d=%b%b want %b%b", if_gnt, d_gnt, m_gnt_if, m_gnt_d);
      end

      if_ok  = if_addr < MEMSIZE;
      d_ok   = (d_addr < MEMSIZE) && (d_we ? (d_funct3 <= 3'd2) : !(d_funct3 inside {3'd3, 3'd6, 3'd7}));
      exp_rd = (m_gnt_if && if_ok) || (m_gnt_d && d_ok && !d_we);
      exp_wr = m_gnt_d && d_ok && d_we;
      n_cmp++;
      if ({mem_read, mem_write} !== {exp_rd, exp_wr}) begin
         n_bad++;
         $display("FAIL strobes: got rd/wr=%b%b want %b%b", mem_read, mem_write, exp_rd, exp_wr);
      end
      if (m_gnt_if && if_ok) begin
         n_cmp++;
         if ({mem_addr, mem_funct3} !== {if_addr, 3'd2}) begin
            n_bad++;
            $display("FAIL fetch drive: got addr=%h f3=%0d want addr=%h f3=2", mem_addr, mem_funct3, if_addr);
         end
      end else if (m_gnt_d && d_ok) begin
         n_cmp++;
         if ({mem_addr, mem_funct3} !== {d_addr, d_funct3} || (d_we && mem_value !== d_wdata)) begin
            n_bad++;
            $display("FAIL data drive: got addr=%h f3=%0d val=%h want addr=%h f3=%0d val=%h",
                     mem_addr, mem_funct3, mem_value, d_addr, d_funct3, d_wdata);
         end
      end else if (!m_gnt_if && !m_gnt_d) begin
         n_cmp++;
         if ({mem_addr, mem_value, mem_funct3} !== '0) begin
            n_bad++;
            $display("FAIL idle drive: got addr=%h val=%h f3=%0d want all 0", mem_addr, mem_value, mem_funct3);
         end
      end

      nx = '0;
      if (m_gnt_if) begin
         nx.if_v = 1'b1;
         nx.if_e = !if_ok;
         nx.if_d = if_ok ? ref_mem[if_addr[5:0]] : 32'd0;
         m_last  = 1'b0;
      end else if (m_gnt_d) begin
         nx.d_v = 1'b1;
         nx.d_e = !d_ok;
         nx.d_d = (d_ok && !d_we) ? ld_val(ref_mem[d_addr[5:0]], d_funct3) : 32'd0;
         if (d_ok && d_we) ref_mem[d_addr[5:0]] = st_val(ref_mem[d_addr[5:0]], d_wdata, d_funct3);
         m_last = 1'b1;
      end
      sbq.push_back(nx);
   endtask

   task automatic idle_inputs();
      if_req = 1'b0; if_addr = '0;
      d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_funct3 = '0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      if_req = 1'b1; if_addr = 32'd5;
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'd2; d_wdata = 32'hdead_beef; d_funct3 = 3'd2;
      cycle();
      n_cmp++;
      if ({if_gnt, d_gnt, mem_read, mem_write, mem_addr, mem_value, mem_funct3} !== '0) begin
         n_bad++;
         $display("FAIL reset outputs: gnt=%b%b rd=%b wr=%b addr=%h val=%h f3=%0d want all 0",
                  if_gnt, d_gnt, mem_read, mem_write, mem_addr, mem_value, mem_funct3);
      end
      tick();
      init_mem = 1'b0;
      idle_inputs();
      cycle();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_fetch_only();
      if_req = 1'b1; if_addr = 32'd5;
      cycle();
      n_cmp++;
      if ({if_gnt, mem_read} !== 2'b11) begin
         n_bad++;
         $display("FAIL fetch grant: got gnt=%b rd=%b want 1 1", if_gnt, mem_read);
      end
      tick();
      if_req = 1'b0;
      cycle();
      n_cmp++;
      if (if_rvalid !== 1'b1 || if_rdata !== 32'h1234_5678) begin
         n_bad++;
         $display("FAIL fetch data: got v=%b d=%h want 1 12345678", if_rvalid, if_rdata);
      end
      tick();
   endtask

   task automatic test_round_robin();
      logic [1:0] order [4];
      order[0] = 2'b01; order[1] = 2'b10; order[2] = 2'b01; order[3] = 2'b10;
      reset = 1'b1;
      sbq.delete();
      m_last = 1'b0;
      if_req = 1'b1; if_addr = 32'd5;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'd5; d_funct3 = 3'd4;
      cycle();
      tick();
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cycle();
         n_cmp++;
         if ({if_gnt, d_gnt} !== order[i]) begin
            n_bad++;
            $display("FAIL rr cycle %0d: got if/d=%b%b want %b", i, if_gnt, d_gnt, order[i]);
         end
         tick();
      end
      idle_inputs();
      cycle();
      tick();
   endtask

   task automatic test_store_load();
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'd3; d_wdata = 32'hFFFF_FF80; d_funct3 = 3'd0;
      cycle();
      n_cmp++;
      if ({d_gnt, mem_write, mem_value} !== {2'b11, 32'hFFFF_FF80}) begin
         n_bad++;
         $display("FAIL store drive: got gnt=%b wr=%b val=%h want 1 1 ffffff80", d_gnt, mem_write, mem_value);
      end
      tick();
      d_we = 1'b0; d_funct3 = 3'd0;
      cycle();
      n_cmp++;
      if (d_rvalid !== 1'b1 || d_rdata !== 32'd0) begin
         n_bad++;
         $display("FAIL store resp: got v=%b d=%h want 1 00000000", d_rvalid, d_rdata);
      end
      tick();
      d_funct3 = 3'd4;
      cycle();
      n_cmp++;
      if (d_rdata !== 32'hFFFF_FF80) begin
         n_bad++;
         $display("FAIL lb: got %h want ffffff80", d_rdata);
      end
      tick();
      idle_inputs();
      cycle();
      n_cmp++;
      if (d_rdata !== 32'h0000_0080) begin
         n_bad++;
         $display("FAIL lbu: got %h want 00000080", d_rdata);
      end
      tick();
   endtask

   task automatic test_illegal();
      if_req = 1'b1; if_addr = 32'd64;
      cycle();
      n_cmp++;
      if ({if_gnt, mem_read} !== 2'b10) begin
         n_bad++;
         $display("FAIL bad fetch grant: got gnt=%b rd=%b want 1 0", if_gnt, mem_read);
      end
      tick();
      if_req = 1'b0;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'd1; d_funct3 = 3'd7;
      cycle();
      n_cmp++;
      if ({if_rvalid, if_err, if_rdata, d_gnt, mem_read} !== {2'b11, 32'd0, 2'b10}) begin
         n_bad++;
         $display("FAIL bad fetch resp: got v=%b e=%b d=%h dgnt=%b rd=%b want 1 1 0 1 0",
                  if_rvalid, if_err, if_rdata, d_gnt, mem_read);
      end
      tick();
      d_we = 1'b1; d_funct3 = 3'd3; d_wdata = 32'h5555_aaaa; d_addr = 32'd2;
      cycle();
      n_cmp++;
      if ({d_rvalid, d_err, d_rdata} !== {2'b11, 32'd0}) begin
         n_bad++;
         $display("FAIL bad load resp: got v=%b e=%b d=%h want 1 1 0", d_rvalid, d_err, d_rdata);
      end
      tick();
      d_we = 1'b0; d_funct3 = 3'd2; d_addr = 32'd63;
      cycle();
      tick();
      d_funct3 = 3'd6; d_addr = 32'd0;
      cycle();
      tick();
      idle_inputs();
      cycle();
      tick();
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 60; i++) begin
         if (!if_req || m_gnt_if) begin
            if_req  = ($urandom_range(0, 3) != 0);
            if_addr = 32'($urandom_range(0, 70));
         end
         if (!d_req || m_gnt_d) begin
            d_req    = ($urandom_range(0, 3) != 0);
            d_we     = 1'($urandom_range(0, 1));
            d_addr   = 32'($urandom_range(0, 70));
            d_wdata  = $urandom;
            d_funct3 = 3'($urandom_range(0, 7));
         end
         cycle();
         tick();
      end
      idle_inputs();
      cycle();
      tick();
   endtask

   task automatic test_reset_midflight();
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'd5; d_funct3 = 3'd2;
      cycle();
      n_cmp++;
      if (d_gnt !== 1'b1) begin
         n_bad++;
         $display("FAIL midflight grant: got %b want 1", d_gnt);
      end
      #1;
      reset = 1'b1;
      sbq.delete();
      m_last = 1'b0;
      tick();
      n_cmp++;
      if (d_rvalid !== 1'b0) begin
         n_bad++;
         $display("FAIL midflight drop: got d_rvalid=%b want 0", d_rvalid);
      end
      if_req = 1'b1; if_addr = 32'd5;
      cycle();
      tick();
      reset = 1'b0;
      cycle();
      n_cmp++;
      if ({if_gnt, d_gnt, d_rvalid} !== 3'b010) begin
         n_bad++;
         $display("FAIL post-reset tie: got if/d gnt=%b%b d_rvalid=%b want 01 0", if_gnt, d_gnt, d_rvalid);
      end
      tick();
      idle_inputs();
      cycle();
      tick();
   endtask

   initial begin
      init_mem = 1'b1;
      m_last   = 1'b0;
      m_gnt_if = 1'b0;
      m_gnt_d  = 1'b0;
      for (int i = 0; i < MEMSIZE; i++) ref_mem[i] = (i == 5) ? 32'h1234_5678 : 32'd0;
      test_reset();
      test_fetch_only();
      test_round_robin();
      test_store_load();
      test_illegal();
      test_back_to_back();
      test_reset_midflight();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
